// File: rtl/lsu_if.sv
// lsu_if
// Data-memory bus between the load/store stage and the data memory.
// A request (req) carries a word-aligned address, byte enables, write
// data and the write strobe. The memory accepts it with gnt in the same
// cycle and returns read data with rvalid at least one cycle later.
//
// Signals:
//   req    master->slave  access request
//   we     master->slave  1 = store, 0 = load
//   addr   master->slave  word-aligned byte address
//   be     master->slave  byte-lane enables
//   wdata  master->slave  store data, replicated across lanes
//   gnt    slave->master  request accepted this cycle
//   rvalid slave->master  response valid (read data / store ack)
//   rdata  slave->master  read data word
interface lsu_if;
  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [3:0]  be;
  logic [31:0] wdata;
  logic        gnt;
  logic        rvalid;
  logic [31:0] rdata;

  modport master (
    output req, we, addr, be, wdata,
    input  gnt, rvalid, rdata
  );

  modport slave (
    input  req, we, addr, be, wdata,
    output gnt, rvalid, rdata
  );
endinterface

// File: rtl/lsu.sv
// lsu
// Load/store stage of the 5-stage RV32 core, between the EX/LSU pipeline
// register and the lsu_wb register. Memory instructions are issued on the
// dmem bus with byte-lane alignment for stores and sign/zero extension
// for loads; the upstream pipeline is stalled while an access is in
// flight. Non-memory instructions pass straight through to lsu_wb.
//
// Ports:
//   clk, rst_n            clock (rising edge), async active-low reset
//   ex_valid              instruction present at EX/LSU register
//   ex_pc, ex_inst        PC / instruction word
//   ex_alu_result         effective address (mem ops) or ALU result
//   ex_mem_rd, ex_mem_wr  load / store
//   ex_funct3             access size/sign (B, H, W, BU, HU)
//   ex_store_data         rs2 value for stores
//   ex_wr_reg_en/_addr    register write request / destination
//   dmem                  data-memory bus (lsu_if master)
//   lsu_stall             hold all upstream stages
//   lsu_misalign          misaligned-access flag
//   lsu_*_o               write-back bundle to lsu_wb
module lsu (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ex_valid,
  input  logic [31:0] ex_pc,
  input  logic [31:0] ex_inst,
  input  logic [31:0] ex_alu_result,
  input  logic        ex_mem_rd,
  input  logic        ex_mem_wr,
  input  logic [2:0]  ex_funct3,
  input  logic [31:0] ex_store_data,
  input  logic        ex_wr_reg_en,
  input  logic [4:0]  ex_wr_reg_addr,
  lsu_if.master       dmem,
  output logic        lsu_stall,
  output logic        lsu_misalign,
  output logic [31:0] lsu_reg_wdata_o,
  output logic        lsu_wr_reg_en_o,
  output logic [4:0]  lsu_wr_reg_addr_o,
  output logic [31:0] lsu_pc_o,
  output logic [31:0] lsu_inst_o
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_RESP = 2'd1,
    DONE      = 2'd2
  } state_e;

  // Access size is carried in funct3[1:0]; funct3[2] selects zero-extension.
  // Any size code other than byte/half is handled as a word.
  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;

  function automatic logic is_misaligned(input logic [2:0] f3,
                                         input logic [1:0] a);
    case (f3[1:0])
      SZ_B:    return 1'b0;
      SZ_H:    return a[0];
      default: return (a != 2'b00);
    endcase
  endfunction

  function automatic logic [3:0] store_be(input logic [2:0] f3,
                                          input logic [1:0] a);
    case (f3[1:0])
      SZ_B:    return 4'b0001 << a;
      SZ_H:    return 4'b0011 << a;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] store_wdata(input logic [2:0]  f3,
                                              input logic [31:0] d);
    case (f3[1:0])
      SZ_B:    return {4{d[7:0]}};
      SZ_H:    return {2{d[15:0]}};
      default: return d;
    endcase
  endfunction

  function automatic logic [31:0] load_format(input logic [2:0]  f3,
                                              input logic [1:0]  a,
                                              input logic [31:0] rdata);
    logic        [31:0] sh_b;
    logic        [31:0] sh_h;
    logic signed [7:0]  byte_s;
    logic signed [15:0] half_s;
    sh_b   = rdata >> {a, 3'b000};
    sh_h   = rdata >> {a[1], 4'b0000};
    byte_s = sh_b[7:0];
    half_s = sh_h[15:0];
    case (f3)
      3'b000:  return 32'(byte_s);
      3'b001:  return 32'(half_s);
      3'b100:  return {24'h0, byte_s};
      3'b101:  return {16'h0, half_s};
      default: return rdata;
    endcase
  endfunction

  state_e      state_q, state_d;
  logic [31:0] result_q, result_d;

  logic mem_op;
  logic misaligned;
  logic access;

  assign mem_op     = ex_valid & (ex_mem_rd | ex_mem_wr);
  assign misaligned = is_misaligned(ex_funct3, ex_alu_result[1:0]);
  assign access     = mem_op & ~misaligned;

  // State and result register. Reset abandons any access in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
    end
  end

  // Next state. gnt only matters in IDLE, rvalid only in WAIT_RESP.
  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    case (state_q)
      IDLE: begin
        if (access && dmem.gnt) state_d = WAIT_RESP;
      end
      WAIT_RESP: begin
        if (dmem.rvalid) begin
          state_d  = DONE;
          result_d = ex_mem_rd ? load_format(ex_funct3, ex_alu_result[1:0],
                                             dmem.rdata)
                               : 32'h0;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs. Everything is forced to zero while reset is asserted so the
  // write-back stage sees a clean bubble regardless of the ex_* inputs.
  always_comb begin
    dmem.req          = 1'b0;
    dmem.we           = 1'b0;
    dmem.addr         = 32'h0;
    dmem.be           = 4'h0;
    dmem.wdata        = 32'h0;
    lsu_stall         = 1'b0;
    lsu_misalign      = 1'b0;
    lsu_reg_wdata_o   = 32'h0;
    lsu_wr_reg_en_o   = 1'b0;
    lsu_wr_reg_addr_o = 5'h0;
    lsu_pc_o          = 32'h0;
    lsu_inst_o        = 32'h0;
    if (rst_n) begin
      case (state_q)
        IDLE: begin
          if (ex_valid) begin
            lsu_pc_o   = ex_pc;
            lsu_inst_o = ex_inst;
            if (!mem_op) begin
              lsu_reg_wdata_o   = ex_alu_result;
              lsu_wr_reg_en_o   = ex_wr_reg_en;
              lsu_wr_reg_addr_o = ex_wr_reg_addr;
            end else if (misaligned) begin
              // Flag lasts one cycle because no stall is raised and the
              // pipeline moves on.
              lsu_misalign = 1'b1;
            end else begin
              // Request stays up with stable fields until granted; the
              // stall keeps ex_* (and hence these fields) frozen.
              dmem.req   = 1'b1;
              dmem.we    = ex_mem_wr;
              dmem.addr  = {ex_alu_result[31:2], 2'b00};
              dmem.be    = store_be(ex_funct3, ex_alu_result[1:0]);
              dmem.wdata = store_wdata(ex_funct3, ex_store_data);
              lsu_stall  = 1'b1;
            end
          end
        end
        WAIT_RESP: begin
          lsu_stall  = 1'b1;
          lsu_pc_o   = ex_pc;
          lsu_inst_o = ex_inst;
        end
        DONE: begin
          lsu_reg_wdata_o   = result_q;
          lsu_wr_reg_en_o   = ex_wr_reg_en & ex_mem_rd;
          lsu_wr_reg_addr_o = ex_wr_reg_addr;
          lsu_pc_o          = ex_pc;
          lsu_inst_o        = ex_inst;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu.sv
module tb_lsu;

  typedef struct packed {
    logic [31:0] wdata;
    logic        wr_en;
    logic [4:0]  waddr;
    logic [31:0] pc;
    logic [31:0] inst;
  } res_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ex_valid;
  logic [31:0] ex_pc, ex_inst, ex_alu_result, ex_store_data;
  logic        ex_mem_rd, ex_mem_wr, ex_wr_reg_en;
  logic [2:0]  ex_funct3;
  logic [4:0]  ex_wr_reg_addr;
  logic        lsu_stall, lsu_misalign, lsu_wr_reg_en_o;
  logic [31:0] lsu_reg_wdata_o, lsu_pc_o, lsu_inst_o;
  logic [4:0]  lsu_wr_reg_addr_o;

  lsu_if dmem_bus ();

  lsu dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .ex_valid          (ex_valid),
    .ex_pc             (ex_pc),
    .ex_inst           (ex_inst),
    .ex_alu_result     (ex_alu_result),
    .ex_mem_rd         (ex_mem_rd),
    .ex_mem_wr         (ex_mem_wr),
    .ex_funct3         (ex_funct3),
    .ex_store_data     (ex_store_data),
    .ex_wr_reg_en      (ex_wr_reg_en),
    .ex_wr_reg_addr    (ex_wr_reg_addr),
    .dmem              (dmem_bus),
    .lsu_stall         (lsu_stall),
    .lsu_misalign      (lsu_misalign),
    .lsu_reg_wdata_o   (lsu_reg_wdata_o),
    .lsu_wr_reg_en_o   (lsu_wr_reg_en_o),
    .lsu_wr_reg_addr_o (lsu_wr_reg_addr_o),
    .lsu_pc_o          (lsu_pc_o),
    .lsu_inst_o        (lsu_inst_o)
  );

  always #5 clk = ~clk;

  int   n_vec = 0;
  int   n_err = 0;
  res_t sb_q[$];

  // Bus fields captured on the first request cycle of an access.
  logic        b_we;
  logic [3:0]  b_be;
  logic [31:0] b_wdata, b_addr;

  task automatic set_ex(input logic v, input logic [31:0] pc, inst, addr,
                        input logic rd, wr, input logic [2:0] f3,
                        input logic [31:0] sdata, input logic wen,
                        input logic [4:0] wad);
    ex_valid = v; ex_pc = pc; ex_inst = inst; ex_alu_result = addr;
    ex_mem_rd = rd; ex_mem_wr = wr; ex_funct3 = f3; ex_store_data = sdata;
    ex_wr_reg_en = wen; ex_wr_reg_addr = wad;
  endtask

  // Plays the memory side of one access: grants after gdly refused request
  // cycles, returns rvalid after rvdly empty wait cycles. Returns the
  // write-back bundle seen in the first unstalled cycle after the response.
  task automatic do_access(input logic [31:0] pc, inst, addr,
                           input logic rd, wr, input logic [2:0] f3,
                           input logic [31:0] sdata, input logic wen,
                           input logic [4:0] wad, input int gdly, rvdly,
                           input logic [31:0] rdata, output res_t o,
                           output int stalls, cycles, reqs, addr_chg,
                           output logic to);
    logic granted = 1'b0;
    logic rv_done = 1'b0;
    int   wait_cnt = 0;
    stalls = 0; cycles = 0; reqs = 0; addr_chg = 0; to = 1'b1; o = '0;
    set_ex(1'b1, pc, inst, addr, rd, wr, f3, sdata, wen, wad);
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      cycles++;
      if (lsu_stall) stalls++;
      if (rv_done && !lsu_stall) begin
        o = '{lsu_reg_wdata_o, lsu_wr_reg_en_o, lsu_wr_reg_addr_o,
              lsu_pc_o, lsu_inst_o};
        to = 1'b0;
        break;
      end
      if (dmem_bus.req) begin
        reqs++;
        if (reqs == 1) begin
          b_we = dmem_bus.we; b_be = dmem_bus.be;
          b_wdata = dmem_bus.wdata; b_addr = dmem_bus.addr;
        end else if (dmem_bus.addr !== b_addr) addr_chg++;
        if (reqs > gdly) begin
          dmem_bus.gnt = 1'b1;
          granted = 1'b1;
        end
      end else if (granted && !rv_done) begin
        wait_cnt++;
        if (wait_cnt > rvdly) begin
          dmem_bus.rvalid = 1'b1;
          dmem_bus.rdata  = rdata;
          rv_done = 1'b1;
        end
      end
      @(posedge clk); #1;
      dmem_bus.gnt = 1'b0; dmem_bus.rvalid = 1'b0;
      dmem_bus.rdata = 32'h5A5A_5A5A;
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset;
    set_ex(1'b1, 32'h10, 32'h0000_2503, 32'h20, 1'b1, 1'b0, 3'b010,
           32'h0, 1'b1, 5'd10);
    dmem_bus.gnt = 1'b1; dmem_bus.rvalid = 1'b1; dmem_bus.rdata = 32'hFFFF_FFFF;
    #7;
    n_vec++; if (dmem_bus.req !== 1'b0) begin n_err++; $display("FAIL rst_req: got %b want 0", dmem_bus.req); end
    n_vec++; if (lsu_stall !== 1'b0) begin n_err++; $display("FAIL rst_stall: got %b want 0", lsu_stall); end
    n_vec++; if (lsu_wr_reg_en_o !== 1'b0) begin n_err++; $display("FAIL rst_wren: got %b want 0", lsu_wr_reg_en_o); end
    n_vec++; if (lsu_pc_o !== 32'h0) begin n_err++; $display("FAIL rst_pc: got %h want 0", lsu_pc_o); end
    ex_mem_rd = 1'b0; ex_alu_result = 32'h55; #1;
    n_vec++; if (lsu_reg_wdata_o !== 32'h0) begin n_err++; $display("FAIL rst_wdata: got %h want 0", lsu_reg_wdata_o); end
    n_vec++; if (lsu_misalign !== 1'b0) begin n_err++; $display("FAIL rst_misalign: got %b want 0", lsu_misalign); end
    dmem_bus.gnt = 1'b0; dmem_bus.rvalid = 1'b0; ex_valid = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_loads;
    logic [31:0] a_t[5]  = '{32'h103, 32'h103, 32'h102, 32'h100, 32'h101};
    logic [2:0]  f_t[5]  = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b000};
    logic [31:0] e_t[5]  = '{32'hFFFF_FF80, 32'h0000_0080, 32'hFFFF_80FF,
                             32'h0000_1234, 32'h0000_0012};
    res_t o, e;
    int   st, cy, rq, ac;
    logic to;
    for (int i = 0; i < 5; i++) begin
      sb_q.push_back('{e_t[i], 1'b1, 5'd7, 32'h2000 + 32'(i*4), 32'h0030_0383});
      do_access(32'h2000 + 32'(i*4), 32'h0030_0383, a_t[i], 1'b1, 1'b0,
                f_t[i], 32'hFFFF_FFFF, 1'b1, 5'd7, 0, 0, 32'h80FF_1234,
                o, st, cy, rq, ac, to);
      ex_valid = 1'b0;
      e = sb_q.pop_front();
      n_vec++; if (to !== 1'b0) begin n_err++; $display("FAIL load%0d_timeout: got %b want 0", i, to); end
      n_vec++; if (o.wdata !== e.wdata) begin n_err++; $display("FAIL load%0d_wdata: got %h want %h", i, o.wdata, e.wdata); end
      n_vec++; if (o.wr_en !== e.wr_en || o.waddr !== e.waddr) begin n_err++; $display("FAIL load%0d_wr: got %b/%0d want %b/%0d", i, o.wr_en, o.waddr, e.wr_en, e.waddr); end
      n_vec++; if (o.pc !== e.pc || o.inst !== e.inst) begin n_err++; $display("FAIL load%0d_pcinst: got %h/%h want %h/%h", i, o.pc, o.inst, e.pc, e.inst); end
      n_vec++; if (cy !== 3 || st !== 2) begin n_err++; $display("FAIL load%0d_latency: got %0d cycles %0d stalls want 3/2", i, cy, st); end
      n_vec++; if (b_addr !== 32'h100 || b_we !== 1'b0) begin n_err++; $display("FAIL load%0d_bus: got %h we=%b want 00000100 we=0", i, b_addr, b_we); end
    end
  endtask

  task automatic test_stores;
    logic [31:0] a_t[3] = '{32'h202, 32'h201, 32'h300};
    logic [2:0]  f_t[3] = '{3'b001, 3'b000, 3'b010};
    logic [31:0] d_t[3] = '{32'h0000_ABCD, 32'h1234_56EF, 32'h1234_5678};
    logic [3:0]  be_t[3] = '{4'b1100, 4'b0010, 4'b1111};
    logic [31:0] wd_t[3] = '{32'hABCD_ABCD, 32'hEFEF_EFEF, 32'h1234_5678};
    logic [31:0] ad_t[3] = '{32'h200, 32'h200, 32'h300};
    res_t o, e;
    int   st, cy, rq, ac;
    logic to;
    for (int i = 0; i < 3; i++) begin
      sb_q.push_back('{32'h0, 1'b0, 5'd3, 32'h3000, 32'h00A5_1123});
      // wr_reg_en raised on purpose: a store must still not write back.
      do_access(32'h3000, 32'h00A5_1123, a_t[i], 1'b0, 1'b1, f_t[i], d_t[i],
                1'b1, 5'd3, 0, 0, 32'hCAFE_F00D, o, st, cy, rq, ac, to);
      ex_valid = 1'b0;
      e = sb_q.pop_front();
      n_vec++; if (to !== 1'b0) begin n_err++; $display("FAIL store%0d_timeout: got %b want 0", i, to); end
      n_vec++; if (b_be !== be_t[i]) begin n_err++; $display("FAIL store%0d_be: got %b want %b", i, b_be, be_t[i]); end
      n_vec++; if (b_wdata !== wd_t[i]) begin n_err++; $display("FAIL store%0d_wdata: got %h want %h", i, b_wdata, wd_t[i]); end
      n_vec++; if (b_addr !== ad_t[i] || b_we !== 1'b1) begin n_err++; $display("FAIL store%0d_addr: got %h we=%b want %h we=1", i, b_addr, b_we, ad_t[i]); end
      n_vec++; if (o.wr_en !== e.wr_en || o.wdata !== e.wdata) begin n_err++; $display("FAIL store%0d_wb: got %b/%h want %b/%h", i, o.wr_en, o.wdata, e.wr_en, e.wdata); end
    end
  endtask

  task automatic test_delayed;
    res_t o, e;
    int   st, cy, rq, ac;
    logic to;
    sb_q.push_back('{32'hDEAD_BEEF, 1'b1, 5'd12, 32'h4000, 32'h0004_2603});
    do_access(32'h4000, 32'h0004_2603, 32'h404, 1'b1, 1'b0, 3'b010, 32'h0,
              1'b1, 5'd12, 2, 3, 32'hDEAD_BEEF, o, st, cy, rq, ac, to);
    ex_valid = 1'b0;
    e = sb_q.pop_front();
    n_vec++; if (to !== 1'b0) begin n_err++; $display("FAIL dly_timeout: got %b want 0", to); end
    n_vec++; if (rq !== 3 || ac !== 0) begin n_err++; $display("FAIL dly_req_hold: got %0d req cycles %0d addr changes want 3/0", rq, ac); end
    n_vec++; if (st !== 7 || cy !== 8) begin n_err++; $display("FAIL dly_stall: got %0d stalls %0d cycles want 7/8", st, cy); end
    n_vec++; if (o.wdata !== e.wdata || o.wr_en !== e.wr_en) begin n_err++; $display("FAIL dly_result: got %h/%b want %h/%b", o.wdata, o.wr_en, e.wdata, e.wr_en); end
    n_vec++; if (b_addr !== 32'h404) begin n_err++; $display("FAIL dly_addr: got %h want 00000404", b_addr); end
  endtask

  task automatic test_misalign;
    logic [31:0] a_t[3] = '{32'h101, 32'h102, 32'h301};
    logic [2:0]  f_t[3] = '{3'b001, 3'b010, 3'b010};
    logic        w_t[3] = '{1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 3; i++) begin
      set_ex(1'b1, 32'h5000, 32'h0010_9283, a_t[i], ~w_t[i], w_t[i], f_t[i],
             32'h1, 1'b1, 5'd5);
      @(negedge clk);
      n_vec++; if (lsu_misalign !== 1'b1 || dmem_bus.req !== 1'b0) begin n_err++; $display("FAIL mis%0d_flag: got mis=%b req=%b want 1/0", i, lsu_misalign, dmem_bus.req); end
      n_vec++; if (lsu_stall !== 1'b0 || lsu_wr_reg_en_o !== 1'b0) begin n_err++; $display("FAIL mis%0d_ctl: got stall=%b wren=%b want 0/0", i, lsu_stall, lsu_wr_reg_en_o); end
      n_vec++; if (lsu_pc_o !== 32'h5000 || lsu_inst_o !== 32'h0010_9283) begin n_err++; $display("FAIL mis%0d_pc: got %h/%h want 00005000/00109283", i, lsu_pc_o, lsu_inst_o); end
      @(posedge clk); #1;
      ex_valid = 1'b0;
      @(negedge clk);
      n_vec++; if (lsu_misalign !== 1'b0) begin n_err++; $display("FAIL mis%0d_oneshot: got %b want 0", i, lsu_misalign); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_passthrough;
    res_t e;
    set_ex(1'b1, 32'h6000, 32'h00B5_0533, 32'h55, 1'b0, 1'b0, 3'b000,
           32'h77, 1'b1, 5'd10);
    sb_q.push_back('{32'h55, 1'b1, 5'd10, 32'h6000, 32'h00B5_0533});
    @(negedge clk);
    e = sb_q.pop_front();
    n_vec++; if (lsu_reg_wdata_o !== e.wdata || lsu_wr_reg_en_o !== e.wr_en || lsu_wr_reg_addr_o !== e.waddr) begin n_err++; $display("FAIL add_wb: got %h/%b/%0d want %h/%b/%0d", lsu_reg_wdata_o, lsu_wr_reg_en_o, lsu_wr_reg_addr_o, e.wdata, e.wr_en, e.waddr); end
    n_vec++; if (lsu_pc_o !== e.pc || lsu_inst_o !== e.inst) begin n_err++; $display("FAIL add_pcinst: got %h/%h want %h/%h", lsu_pc_o, lsu_inst_o, e.pc, e.inst); end
    n_vec++; if (lsu_stall !== 1'b0 || dmem_bus.req !== 1'b0) begin n_err++; $display("FAIL add_ctl: got stall=%b req=%b want 0/0", lsu_stall, dmem_bus.req); end
    @(posedge clk); #1;
    ex_valid = 1'b0;
    @(negedge clk);
    n_vec++; if (lsu_reg_wdata_o !== 32'h0 || lsu_wr_reg_en_o !== 1'b0 || lsu_wr_reg_addr_o !== 5'h0) begin n_err++; $display("FAIL bubble_wb: got %h/%b/%0d want 0/0/0", lsu_reg_wdata_o, lsu_wr_reg_en_o, lsu_wr_reg_addr_o); end
    n_vec++; if (lsu_pc_o !== 32'h0 || lsu_inst_o !== 32'h0 || lsu_stall !== 1'b0) begin n_err++; $display("FAIL bubble_pc: got %h/%h stall=%b want 0/0/0", lsu_pc_o, lsu_inst_o, lsu_stall); end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid;
    res_t o, e;
    int   st, cy, rq, ac;
    logic to;
    set_ex(1'b1, 32'h7000, 32'h0005_2503, 32'h500, 1'b1, 1'b0, 3'b010,
           32'h0, 1'b1, 5'd10);
    @(negedge clk);
    n_vec++; if (dmem_bus.req !== 1'b1) begin n_err++; $display("FAIL rmid_req: got %b want 1", dmem_bus.req); end
    dmem_bus.gnt = 1'b1;
    @(posedge clk); #1; dmem_bus.gnt = 1'b0;
    @(negedge clk);
    n_vec++; if (lsu_stall !== 1'b1 || dmem_bus.req !== 1'b0) begin n_err++; $display("FAIL rmid_wait: got stall=%b req=%b want 1/0", lsu_stall, dmem_bus.req); end
    #1; rst_n = 1'b0; #1;
    n_vec++; if (lsu_stall !== 1'b0 || lsu_pc_o !== 32'h0 || lsu_wr_reg_en_o !== 1'b0) begin n_err++; $display("FAIL rmid_zero: got stall=%b pc=%h wren=%b want 0/0/0", lsu_stall, lsu_pc_o, lsu_wr_reg_en_o); end
    dmem_bus.rvalid = 1'b1; dmem_bus.rdata = 32'h1111_1111;
    @(posedge clk); #1; dmem_bus.rvalid = 1'b0; rst_n = 1'b1;
    ex_valid = 1'b0;
    @(negedge clk); dmem_bus.rvalid = 1'b1;
    @(posedge clk); #1; dmem_bus.rvalid = 1'b0;
    @(negedge clk);
    // ex_pc is still 0x7000: a stray DONE state would expose it.
    n_vec++; if (lsu_pc_o !== 32'h0 || lsu_wr_reg_en_o !== 1'b0 || lsu_stall !== 1'b0) begin n_err++; $display("FAIL rmid_ignored: got pc=%h wren=%b stall=%b want 0/0/0", lsu_pc_o, lsu_wr_reg_en_o, lsu_stall); end
    @(posedge clk); #1;
    sb_q.push_back('{32'h2468_ACE0, 1'b1, 5'd11, 32'h7004, 32'h0005_2583});
    do_access(32'h7004, 32'h0005_2583, 32'h508, 1'b1, 1'b0, 3'b010, 32'h0,
              1'b1, 5'd11, 0, 0, 32'h2468_ACE0, o, st, cy, rq, ac, to);
    ex_valid = 1'b0;
    e = sb_q.pop_front();
    n_vec++; if (to !== 1'b0 || cy !== 3) begin n_err++; $display("FAIL rmid_new_lat: got to=%b cycles=%0d want 0/3", to, cy); end
    n_vec++; if (o.wdata !== e.wdata || o.wr_en !== e.wr_en || o.waddr !== e.waddr) begin n_err++; $display("FAIL rmid_new_wb: got %h/%b/%0d want %h/%b/%0d", o.wdata, o.wr_en, o.waddr, e.wdata, e.wr_en, e.waddr); end
  endtask

  task automatic test_back_to_back;
    res_t o, e;
    int   st, cy, rq, ac;
    logic to;
    sb_q.push_back('{32'h0BAD_CAFE, 1'b1, 5'd1, 32'h8000, 32'h0000_2083});
    sb_q.push_back('{32'hFFFF_FFFE, 1'b1, 5'd2, 32'h8004, 32'h0000_0103});
    do_access(32'h8000, 32'h0000_2083, 32'h600, 1'b1, 1'b0, 3'b010, 32'h0,
              1'b1, 5'd1, 1, 0, 32'h0BAD_CAFE, o, st, cy, rq, ac, to);
    e = sb_q.pop_front();
    n_vec++; if (to !== 1'b0 || o.wdata !== e.wdata || o.waddr !== e.waddr) begin n_err++; $display("FAIL b2b0: got to=%b %h/%0d want 0 %h/%0d", to, o.wdata, o.waddr, e.wdata, e.waddr); end
    do_access(32'h8004, 32'h0000_0103, 32'h604, 1'b1, 1'b0, 3'b000, 32'h0,
              1'b1, 5'd2, 0, 1, 32'h7777_77FE, o, st, cy, rq, ac, to);
    ex_valid = 1'b0;
    e = sb_q.pop_front();
    n_vec++; if (to !== 1'b0 || o.wdata !== e.wdata || o.pc !== e.pc) begin n_err++; $display("FAIL b2b1: got to=%b %h/%h want 0 %h/%h", to, o.wdata, o.pc, e.wdata, e.pc); end
    n_vec++; if (cy !== 4 || st !== 3) begin n_err++; $display("FAIL b2b1_lat: got %0d cycles %0d stalls want 4/3", cy, st); end
  endtask

  initial begin
    rst_n = 1'b0;
    set_ex(1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 3'b000, 32'h0, 1'b0, 5'd0);
    dmem_bus.gnt = 1'b0; dmem_bus.rvalid = 1'b0; dmem_bus.rdata = 32'h5A5A_5A5A;
    test_reset;
    test_loads;
    test_stores;
    test_delayed;
    test_misalign;
    test_passthrough;
    test_reset_mid;
    test_back_to_back;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
